// File: rtl/coherence_bus_ctrl_pkg.sv
// coherence_bus_ctrl_pkg: shared bus FSM states and fixed geometry for the two-core coherence bus controller
package coherence_bus_ctrl_pkg;
  localparam int CPUS = 2;
  localparam int BLKWORDS = 2;
  typedef enum logic [2:0] {IDLE, WB, IF, SNOOP, XFER1, XFER2, RAM1, RAM2} busstate_t;
endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if: cache-side and RAM-side bus signals of the coherence bus controller
// slave: controller view (cache requests and RAM responses in, waits/data/snoops/RAM commands out)
// master: environment view (caches plus RAM)
interface coherence_bus_ctrl_if;
  import coherence_bus_ctrl_pkg::*;
  logic [CPUS-1:0] iren, iwait, dren, dwen, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS-1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic ram_ren, ram_wen, ram_wait;
  logic [31:0] ram_addr, ram_store, ram_load;
  modport slave (
    input iren, iaddr, dren, dwen, daddr, dstore, cctrans, ccwrite, ram_load, ram_wait,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store
  );
  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, cctrans, ccwrite, ram_load, ram_wait,
    input iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter2.sv
// coherence_bus_ctrl_rr_arbiter2: two-requester round-robin arbiter
// ports: clk, rst_n (async active-low), req[1:0] requests, adv toggles the priority pointer,
//        grant = winning index, any = some request present
module coherence_bus_ctrl_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       grant,
  output logic       any
);
  logic ptr;
  assign any = |req;
  // the pointer only matters on a tie; a lone requester always wins
  assign grant = &req ? ptr : req[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (adv) ptr <= ~ptr;
endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core MSI bus controller arbitrating icache fetches, dcache misses and write-backs onto one RAM port
// ports: clk, rst_n (async active-low), bus (slave modport of coherence_bus_ctrl_if)
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  coherence_bus_ctrl_if.slave bus
);
  busstate_t state, state_n;
  logic req, req_n, oth, dgrant, igrant, dany, iany, dadv, iadv;
  logic [1:0] wb, cr;
  assign wb = bus.dwen & ~bus.cctrans;
  assign cr = bus.dren & bus.cctrans;
  assign oth = ~req;
  // plain write-backs and coherent misses share the dcache pointer; write-backs win the class
  coherence_bus_ctrl_rr_arbiter2 u_darb (
    .clk(clk), .rst_n(rst_n), .req(|wb ? wb : cr), .adv(dadv), .grant(dgrant), .any(dany)
  );
  coherence_bus_ctrl_rr_arbiter2 u_iarb (
    .clk(clk), .rst_n(rst_n), .req(bus.iren), .adv(iadv), .grant(igrant), .any(iany)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req <= 1'b0;
    end else begin
      state <= state_n;
      req <= req_n;
    end
  always_comb begin
    state_n = state;
    req_n = req;
    dadv = 1'b0;
    iadv = 1'b0;
    bus.iwait = '1;
    bus.dwait = '1;
    bus.ccwait = '0;
    bus.ccinv = '0;
    bus.ccsnoopaddr = '0;
    bus.iload = '0;
    bus.dload = '0;
    bus.ram_ren = 1'b0;
    bus.ram_wen = 1'b0;
    bus.ram_addr = '0;
    bus.ram_store = '0;
    // the other core stays paused from the snoop until the block has been delivered
    if (state inside {SNOOP, XFER1, XFER2, RAM1, RAM2}) begin
      bus.ccwait[oth] = 1'b1;
      bus.ccsnoopaddr[oth] = bus.daddr[req];
    end
    case (state)
      IDLE: begin
        req_n = (dany || |wb) ? dgrant : igrant;
        state_n = |wb ? WB : dany ? SNOOP : iany ? IF : IDLE;
      end
      WB: begin
        bus.ram_wen = bus.dwen[req];
        bus.ram_addr = bus.daddr[req];
        bus.ram_store = bus.dstore[req];
        bus.dwait[req] = bus.ram_wait;
        if (!bus.dwen[req]) begin
          state_n = IDLE;
          dadv = 1'b1;
        end
      end
      IF: begin
        bus.ram_ren = 1'b1;
        bus.ram_addr = bus.iaddr[req];
        bus.iload[req] = bus.ram_load;
        bus.iwait[req] = bus.ram_wait;
        if (!bus.ram_wait) begin
          state_n = IDLE;
          iadv = 1'b1;
        end
      end
      SNOOP: begin
        bus.ccinv[oth] = bus.ccwrite[req];
        state_n = bus.ccwrite[oth] ? XFER1 : RAM1;
      end
      XFER1, XFER2: begin
        // modified block goes to the requester and to RAM in the same word handshake
        bus.ccinv[oth] = bus.ccwrite[req];
        bus.ram_wen = 1'b1;
        bus.ram_addr = bus.daddr[oth];
        bus.ram_store = bus.dstore[oth];
        bus.dload[req] = bus.dstore[oth];
        bus.dwait = {2{bus.ram_wait}};
        if (!bus.ram_wait) begin
          state_n = state == XFER1 ? XFER2 : IDLE;
          dadv = state == XFER2;
        end
      end
      default: begin
        bus.ram_ren = 1'b1;
        bus.ram_addr = bus.daddr[req];
        bus.dload[req] = bus.ram_load;
        bus.dwait[req] = bus.ram_wait;
        // a requester that drops dren after the first word ends the block early
        if (!bus.ram_wait) begin
          state_n = (state == RAM1 && bus.dren[req]) ? RAM2 : IDLE;
          dadv = !(state == RAM1 && bus.dren[req]);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: scoreboard bench for coherence_bus_ctrl with behavioural caches and a latency-programmable RAM
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;
  typedef struct packed {
    logic [1:0]  kind;
    logic        core;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;
  localparam logic [1:0] KI = 2'd0, KR = 2'd1, KW = 2'd2;

  logic clk, rst_n;
  coherence_bus_ctrl_if bus();
  coherence_bus_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared = 0, mismatched = 0;
  ev_t exp_q[$];

  // RAM: each word completes after lat wait cycles
  logic [31:0] mem [0:4095];
  int lat = 0, cnt = 0;
  assign bus.ram_wait = cnt < lat;
  assign bus.ram_load = mem[bus.ram_addr[13:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[12'h010] <= 32'h2002_0001;
      mem[12'hC40] <= 32'h1111_3100;
      mem[12'hC41] <= 32'h1111_3104;
      mem[12'hC80] <= 32'h5555_3200;
      mem[12'hC81] <= 32'h5555_3204;
      mem[12'hCC0] <= 32'h7777_3300;
      mem[12'hCC1] <= 32'h7777_3304;
      cnt <= 0;
    end else begin
      if (bus.ram_wen && !bus.ram_wait) mem[bus.ram_addr[13:2]] <= bus.ram_store;
      cnt <= ((bus.ram_ren || bus.ram_wen) && bus.ram_wait) ? cnt + 1 : 0;
    end
  end

  // cache models: requests are posted through these flags by the stimulus
  bit ipend[2], wpend[2], dpend[2], mods[2], rx[2];
  logic [31:0] ia[2], wa[2], da[2];
  logic [31:0] wd[2][2], md[2][2];
  int sw[2], ww[2], dw[2];

  initial begin
    bit sup;
    bus.iren = '0; bus.dren = '0; bus.dwen = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (!rst_n) begin
          ipend[c] = 0; wpend[c] = 0; dpend[c] = 0; mods[c] = 0;
          sw[c] = 0; ww[c] = 0; dw[c] = 0;
        end else begin
          if (bus.iren[c] && !bus.iwait[c]) ipend[c] = 0;
          if (bus.dwen[c] && !bus.dwait[c]) begin
            if (bus.ccwait[c]) sw[c]++;
            else ww[c]++;
          end
          if (bus.dren[c] && !bus.dwait[c]) dw[c]++;
          if (sw[c] == BLKWORDS) begin mods[c] = 0; sw[c] = 0; end
          if (ww[c] == BLKWORDS) begin wpend[c] = 0; ww[c] = 0; end
          if (dw[c] == BLKWORDS) begin dpend[c] = 0; dw[c] = 0; end
        end
        sup = bus.ccwait[c] && mods[c];
        bus.iren[c] = ipend[c];
        bus.iaddr[c] = ia[c];
        bus.dwen[c] = sup || (wpend[c] && !bus.ccwait[c]);
        bus.dren[c] = !bus.dwen[c] && dpend[c] && !bus.ccwait[c];
        bus.cctrans[c] = bus.dren[c];
        bus.ccwrite[c] = bus.dren[c] ? rx[c] : mods[c];
        bus.daddr[c] = sup ? (bus.ccsnoopaddr[c] & ~32'h7) + 32'(4 * sw[c])
                     : bus.dwen[c] ? wa[c] + 32'(4 * ww[c]) : da[c] + 32'(4 * dw[c]);
        bus.dstore[c] = sup ? md[c][sw[c]] : wd[c][ww[c]];
      end
    end
  end

  task automatic check_ev(input ev_t got, input string nm);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected event kind=%0d core=%0d addr=%h data=%h", nm, got.kind, got.core, got.addr, got.data);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        mismatched++;
        $display("FAIL %s: got kind=%0d core=%0d addr=%h data=%h, want kind=%0d core=%0d addr=%h data=%h",
                 nm, got.kind, got.core, got.addr, got.data, e.kind, e.core, e.addr, e.data);
      end
    end
  endtask

  // monitor: every completed bus word is matched in order against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_wen && !bus.ram_wait) check_ev('{KW, 1'b0, bus.ram_addr, bus.ram_store}, "ramwrite");
      for (int c = 0; c < 2; c++)
        if (bus.dren[c] && !bus.dwait[c]) check_ev('{KR, c[0], bus.ram_addr, bus.dload[c]}, "dread");
      for (int c = 0; c < 2; c++)
        if (bus.iren[c] && !bus.iwait[c]) check_ev('{KI, c[0], bus.ram_addr, bus.iload[c]}, "ifetch");
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic c, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{k, c, a, d});
  endtask

  int cw0, ci0;
  task automatic wait_idle(input string nm);
    int i;
    cw0 = 0;
    ci0 = 0;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      cw0 += int'(bus.ccwait[0]);
      ci0 += int'(bus.ccinv[0]);
      #2;
      if (!(ipend[0] || ipend[1] || wpend[0] || wpend[1] || dpend[0] || dpend[1] || mods[0] || mods[1])) break;
    end
    compared++;
    if (i == 300) begin
      mismatched++;
      $display("FAIL %s: timeout waiting for completion", nm);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_iwait"}, 32'(bus.iwait), 32'h3);
    chk({nm, "_dwait"}, 32'(bus.dwait), 32'h3);
    chk({nm, "_ramren"}, 32'(bus.ram_ren), 32'h0);
    chk({nm, "_ramwen"}, 32'(bus.ram_wen), 32'h0);
    chk({nm, "_ccwait"}, 32'(bus.ccwait), 32'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("por");
    chk("por_ramaddr", bus.ram_addr, 32'h0);
    rst_n = 1'b1;

    // reset while a RAM read is stuck waiting
    lat = 1000;
    @(posedge clk);
    da[1] = 32'h3100; rx[1] = 0; dpend[1] = 1;
    repeat (6) @(negedge clk);
    chk("stuck_ramren", 32'(bus.ram_ren), 32'h1);
    chk("stuck_ccwait", 32'(bus.ccwait), 32'h1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 reset_checks("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // icache fetch, two RAM wait cycles
    lat = 2;
    @(posedge clk);
    ia[0] = 32'h40; ipend[0] = 1;
    push(KI, 1'b0, 32'h40, 32'h2002_0001);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.iren[0]) n++;
      if (bus.iren[0] && !bus.iwait[0]) break;
    end
    chk("if_cycles", n, 3);
    wait_idle("ifetch");

    // coherent read, snooped core clean
    lat = 0;
    @(posedge clk);
    da[1] = 32'h3100; rx[1] = 0; dpend[1] = 1;
    push(KR, 1'b1, 32'h3100, 32'h1111_3100);
    push(KR, 1'b1, 32'h3104, 32'h1111_3104);
    wait_idle("snoop_clean");
    chk("clean_ccwait_cycles", cw0, 3);
    chk("clean_ccinv_cycles", ci0, 0);

    // coherent read, snooped core holds block Modified
    @(posedge clk);
    mods[0] = 1; md[0][0] = 32'hDEAD_BEEF; md[0][1] = 32'hCAFE_F00D;
    da[1] = 32'h3100; rx[1] = 0; dpend[1] = 1;
    push(KW, 1'b0, 32'h3100, 32'hDEAD_BEEF);
    push(KR, 1'b1, 32'h3100, 32'hDEAD_BEEF);
    push(KW, 1'b0, 32'h3104, 32'hCAFE_F00D);
    push(KR, 1'b1, 32'h3104, 32'hCAFE_F00D);
    wait_idle("xfer_read");
    chk("xfer_ccwait_cycles", cw0, 3);
    chk("xfer_ccinv_cycles", ci0, 0);

    // read-exclusive hitting a Modified block: transfer and invalidate
    @(posedge clk);
    mods[0] = 1; md[0][0] = 32'h0BAD_F00D; md[0][1] = 32'h600D_CAFE;
    da[1] = 32'h3100; rx[1] = 1; dpend[1] = 1;
    push(KW, 1'b0, 32'h3100, 32'h0BAD_F00D);
    push(KR, 1'b1, 32'h3100, 32'h0BAD_F00D);
    push(KW, 1'b0, 32'h3104, 32'h600D_CAFE);
    push(KR, 1'b1, 32'h3104, 32'h600D_CAFE);
    wait_idle("xfer_rdx");
    chk("rdx_ccinv_cycles", ci0, 3);

    // write-back, coherent miss and fetch all at once
    lat = 1;
    @(posedge clk);
    wa[0] = 32'h200; wd[0][0] = 32'h1111_1111; wd[0][1] = 32'h2222_2222; wpend[0] = 1;
    da[1] = 32'h3200; rx[1] = 0; dpend[1] = 1;
    ia[0] = 32'h40; ipend[0] = 1;
    push(KW, 1'b0, 32'h200, 32'h1111_1111);
    push(KW, 1'b0, 32'h204, 32'h2222_2222);
    push(KR, 1'b1, 32'h3200, 32'h5555_3200);
    push(KR, 1'b1, 32'h3204, 32'h5555_3204);
    push(KI, 1'b0, 32'h40, 32'h2002_0001);
    wait_idle("priority");

    // both cores miss the same block: the pointer now favours core 1
    lat = 0;
    @(posedge clk);
    da[0] = 32'h3300; da[1] = 32'h3300; rx[0] = 0; rx[1] = 0; dpend[0] = 1; dpend[1] = 1;
    push(KR, 1'b1, 32'h3300, 32'h7777_3300);
    push(KR, 1'b1, 32'h3304, 32'h7777_3304);
    push(KR, 1'b0, 32'h3300, 32'h7777_3300);
    push(KR, 1'b0, 32'h3304, 32'h7777_3304);
    wait_idle("same_block");

    chk("scoreboard_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Two-core memory bus controller; sits between each core's icache/dcache pair and the single-ported RAM.
- Arbitrates instruction fetches, data read misses and dirty write-backs.
- Sequences MSI snoops: the non-requesting dcache is snooped, and a modified block is supplied cache-to-cache with a simultaneous RAM write-back.
- Blocks are two words; all transfers are word-serial.

Parameters:
- CPUS, 2, number of cores (fixed at 2; arrays indexed [1:0]).
- BLKWORDS, 2, words per cache block.

Ports:
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- iREN  in  [1:0]  icache read request per core.
- iaddr  in  [1:0][31:0]  icache word address.
- iwait  out  [1:0]  1 = icache request not yet complete.
- iload  out  [1:0][31:0]  fetched instruction word.
- dREN  in  [1:0]  dcache read-miss word request.
- dWEN  in  [1:0]  dcache write-back word request (flush, eviction, snoop supply).
- daddr  in  [1:0][31:0]  dcache word address.
- dstore  in  [1:0][31:0]  dcache write data.
- dwait  out  [1:0]  1 = dcache word not yet complete.
- dload  out  [1:0][31:0]  read data to dcache.
- cctrans  in  [1:0]  requester miss is a coherence transaction (qualifies dREN).
- ccwrite  in  [1:0]  with cctrans: read-exclusive (invalidate others); from a snooped cache: "I hold block Modified".
- ccwait  out  [1:0]  1 = this dcache is being snooped; it must pause its own FSM.
- ccinv  out  [1:0]  snooped cache must invalidate the block.
- ccsnoopaddr  out  [1:0][31:0]  snoop address (= requester daddr).
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramwait  in  1  1 = RAM access not complete this cycle.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, both round-robin pointers=0.
  - All wait outputs =1.
  - ccwait, ccinv, ramREN, ramWEN =0; addresses/data =0.
  - Any in-flight access is abandoned; caches restart after reset.
- Defaults every cycle: iwait=dwait=2'b11, ccwait=ccinv=0, RAM controls 0.
- Arbitration in IDLE, first match wins:
  1. dWEN without cctrans (plain write-back).
  2. dREN with cctrans (coherent miss).
  3. iREN.
  - Within a class, ties are broken by the dcache round-robin pointer (dptr) or the icache pointer (iptr).
  - The served core's pointer flips on transaction completion.
  - The granted core index is latched in `req`; the snooped core is `~req`.
- States:
  - IDLE: choose the grant per the priority above; the decision cycle produces no bus activity.
  - WB (dcache write-back): pass dWEN/daddr/dstore[req] to RAM. dwait[req]=ramwait. Stay until the requester deasserts dWEN in IDLE; each word is an independent handshake.
  - IF (icache fetch): ramREN, ramaddr=iaddr[req], iload[req]=ramload, iwait[req]=ramwait. Return to IDLE on ~ramwait.
  - SNOOP:
    - ccwait[~req]=1, ccsnoopaddr[~req]=daddr[req], ccinv[~req]=ccwrite[req]. dwait[req]=1.
    - Held exactly one cycle after the snooped cache sees ccwait.
    - If ccwrite[~req]=1, go to XFER1; else go to RAM1.
  - XFER1/XFER2 (cache-to-cache):
    - ccwait[~req] and ccinv held. The snooped cache drives dWEN, daddr, dstore[~req].
    - ramWEN=1, ramaddr=daddr[~req], ramstore=dstore[~req].
    - dload[req]=dstore[~req]; dwait[req]=dwait[~req]=ramwait.
    - Advance on ~ramwait; XFER2 returns to IDLE.
  - RAM1/RAM2: ramREN=1, ramaddr=daddr[req], dload[req]=ramload, dwait[req]=ramwait. Advance on ~ramwait; RAM2 returns to IDLE. ccwait[~req] is held through RAM2.
- Boundary conditions:
  - Both cores miss on the same block simultaneously: serialized by dptr. The loser is snooped first and completes afterward.
  - Requester drops dREN mid-transaction (e.g. halt): finish the current word, then return to IDLE.
  - Write-back data is never lost: WB outranks coherent reads.
  - Snoop with ccwrite[req]=1 and snooped block Modified: data still transfers and the block is invalidated.
  - ramwait stuck high: the FSM holds, with no timeout.

Decomposition:
- Shared package (cache_pkg): bus state enum busstate_t {IDLE, WB, IF, SNOOP, XFER1, XFER2, RAM1, RAM2}, CPUS, BLKWORDS.
- One sub-module, rr_arbiter2: two-requester round-robin with a priority pointer and an advance input. It is instantiated once each for the dcache and icache classes.

Test Plan:
1. Reset mid-RAM1 (ramwait=1) -> next cycle state=IDLE, iwait=dwait=2'b11, ramREN=0.
2. Core0 iREN at 0x0000_0040, ramwait low after 2 cycles, ramload=0x2002_0001 -> iload[0]=0x2002_0001 when iwait[0] falls. Completion takes exactly 1 arbitration cycle + 3 IF cycles.
3. Core1 dREN+cctrans at 0x0000_3100, core0 snoop ccwrite=0 -> ccwait[0] asserted for 3 cycles, 2 RAM reads. dload[1] receives RAM words at 0x3100 and 0x3104.
4. Same request with core0 ccwrite=1, dstore[0]=0xDEAD_BEEF/0xCAFE_F00D -> ramWEN writes both words. dload[1] shows both values, ccinv[0]=0 (read) or 1 when ccwrite[1]=1.
5. Simultaneous: core0 dWEN (plain), core1 dREN+cctrans, core0 iREN -> served in the order core0 WB, core1 snoop/read, core0 fetch. dptr toggles after each dcache completion.
